fifo_word_byte_unpacker: RTL and testbench
==========================================

// Module: fifo_word_byte_unpacker
// PURPOSE
//  Drains 32-bit received-payload words from the show-ahead-free RX word FIFO (rd_en/dout/empty)
//  and emits them one byte at a time on a valid/ready byte stream that feeds the UART transmitter.
//  Sits between the receive word FIFO and the UART TX; removes rd_en edge-pulse logic from the top.
//  Also reports end-of-frame once a received frame has been fully emitted.
// PARAMETERS
//  MSB_FIRST      1  1: byte [31:24] sent first; 0: byte [7:0] first
//  FIFO_RD_LAT    1  cycles from fifo_rd_en to valid fifo_dout (legal 1..3)
// PORTS
//  clk          in   1   single clock; all logic on posedge clk
//  rst          in   1   synchronous reset, active-high
//  fifo_empty   in   1   word FIFO empty flag
//  fifo_rd_en   out  1   one-cycle read strobe to word FIFO
//  fifo_dout    in   32  word FIFO read data, valid FIFO_RD_LAT cycles after fifo_rd_en
//  rx_finish    in   1   one-cycle pulse: receiver has pushed the last word of a frame
//  tx_data      out  8   byte to UART TX
//  tx_valid     out  1   tx_data valid
//  tx_ready     in   1   UART TX accepts byte when tx_valid&&tx_ready
//  busy         out  1   high in any state other than IDLE
//  frame_done   out  1   one-cycle pulse: frame fully emitted
// BEHAVIOUR
//  Reset: fifo_rd_en=0, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, FSM=IDLE, pending=0.
//  Reset mid-operation aborts; the captured word is discarded, no further bytes are emitted.
//  FSM: IDLE -> RD when !fifo_empty. RD: fifo_rd_en=1 for exactly one cycle -> WAIT.
//   WAIT: count FIFO_RD_LAT-1 cycles (0 means skip), then capture fifo_dout into shift reg -> SEND.
//   SEND: tx_valid=1, tx_data=current byte; on handshake shift to next byte, byte counter +1.
//   After last byte handshake: -> RD if !fifo_empty (back-to-back, no IDLE bubble), else IDLE.
//  Latency: fifo_rd_en to first tx_valid = FIFO_RD_LAT+1 cycles.
//  Handshake: tx_valid never drops and tx_data never changes until accepted; tx_ready while
//   !tx_valid is ignored. Sustained tx_ready=1 gives one byte per cycle.
//  fifo_rd_en never asserted when fifo_empty=1 in the same cycle, nor outside state RD.
//  Byte counter 2 bits (4-bit with macro), wraps to 0 at word end; no partial words.
//  rx_finish sets pending. frame_done pulses one cycle when pending && FSM==IDLE && fifo_empty;
//   pending clears that cycle. rx_finish in the same cycle as frame_done keeps pending set.
//  rx_finish while already pending: no effect (frames do not queue beyond one).
// CONFIGURATION
//  Macro UNPACK_HEX_ASCII_EN:
//   defined: each byte sent as two ASCII hex chars (upper nibble first, '0'-'9','A'-'F'), and
//    each word followed by 8'h0D,8'h0A -> 10 chars per word; counter counts 0..9.
//   undefined: raw binary, 4 bytes per word; hex converter not instantiated.
//  Byte order (MSB_FIRST) applies in both modes.
// STRUCTURE
//  Package fifo_unpack_pkg: FSM state encoding (IDLE,RD,WAIT,SEND), ASCII_CR=8'h0D,
//   ASCII_LF=8'h0A, BYTES_RAW=4, CHARS_HEX=10.
//  Sub-module nibble_to_ascii (4-bit in, 8-bit out, combinational), only under UNPACK_HEX_ASCII_EN.
//  Single FSM + shift register + byte counter + pending flag in this module.
// TESTING
//  1 word 32'hDEADBEEF, tx_ready=1, MSB_FIRST=1 -> bytes DE,AD,BE,EF on consecutive cycles.
//  Same word, MSB_FIRST=0 -> EF,BE,AD,DE; with hex macro -> "DEADBEEF"\r\n (10 chars).
//  tx_ready held 0 for 5 cycles during byte 2 -> tx_valid=1, tx_data stable, no byte skipped.
//  3 words queued, tx_ready=1 -> 12 bytes, exactly 3 fifo_rd_en pulses, no IDLE between words.
//  rx_finish pulse while 2 words remain -> frame_done once, the cycle after last byte + IDLE.
//  rst asserted mid-word (after byte 1) -> next cycle tx_valid=0, busy=0; no bytes until new word.

Source files
------------

// File: rtl/fifo_unpack_pkg.sv
// Shared definitions for the word-to-byte unpacker: FSM encoding and stream constants.
package fifo_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam int         BYTES_RAW = 4;
    localparam int         CHARS_HEX = 10;

endpackage

// File: rtl/fifo_word_byte_unpacker_nibble_to_ascii.sv
// Combinational nibble to ASCII hex character ('0'-'9', 'A'-'F').
// Exists only when UNPACK_HEX_ASCII_EN is defined.
`ifdef UNPACK_HEX_ASCII_EN
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
        else                ascii = 8'h37 + {4'h0, nibble};
    end

endmodule
`endif

// File: rtl/fifo_word_byte_unpacker.sv
// Drains 32-bit words from the RX word FIFO and streams them bytewise to the UART TX.
// Macro UNPACK_HEX_ASCII_EN: emit each word as 8 ASCII hex chars followed by CR, LF.
//   state | meaning
//   IDLE  | waiting for a word in the FIFO
//   RD    | one-cycle read strobe to the FIFO
//   WAIT  | covering the FIFO read latency, then capture the word
//   SEND  | presenting bytes/chars on the valid/ready stream
module fifo_word_byte_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int MSB_FIRST   = 1,
    parameter int FIFO_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_dout,
    input  logic        rx_finish,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

`ifdef UNPACK_HEX_ASCII_EN
    localparam int CNT_W    = 4;
    localparam int LAST_IDX = CHARS_HEX - 1;
`else
    localparam int CNT_W    = 2;
    localparam int LAST_IDX = BYTES_RAW - 1;
`endif
    localparam int LAT_W = 2;

    state_e             state_q, state_d;
    logic [31:0]        shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               pending_q, pending_d;

    logic [7:0]         cur_byte;
    logic [7:0]         tx_byte;
    logic               shift_en;
    logic               hs;
    logic               last;

    assign cur_byte = (MSB_FIRST != 0) ? shift_q[31:24] : shift_q[7:0];

`ifdef UNPACK_HEX_ASCII_EN
    logic [3:0] nibble;
    logic [7:0] nibble_ascii;

    // Upper nibble on even counts; counts 8 and 9 are the CR/LF trailer.
    assign nibble = cnt_q[0] ? cur_byte[3:0] : cur_byte[7:4];

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nibble),
        .ascii  (nibble_ascii)
    );

    always_comb begin
        if (cnt_q == 4'd8)      tx_byte = ASCII_CR;
        else if (cnt_q == 4'd9) tx_byte = ASCII_LF;
        else                    tx_byte = nibble_ascii;
    end

    assign shift_en = cnt_q[0] && (cnt_q < 4'd8);
`else
    assign tx_byte  = cur_byte;
    assign shift_en = 1'b1;
`endif

    assign hs   = (state_q == ST_SEND) && tx_ready;
    assign last = (cnt_q == CNT_W'(LAST_IDX));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_RD;
            ST_RD: begin
                state_d = ST_WAIT;
                lat_d   = LAT_W'(FIFO_RD_LAT - 1);
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (shift_en) begin
                        shift_d = (MSB_FIRST != 0) ? {shift_q[23:0], 8'h00}
                                                   : {8'h00, shift_q[31:8]};
                    end
                    if (last) begin
                        cnt_d   = '0;
                        state_d = fifo_empty ? ST_IDLE : ST_RD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A frame completes only once the FIFO is drained and the FSM has settled in IDLE.
    assign frame_done = pending_q && (state_q == ST_IDLE) && fifo_empty;
    assign pending_d  = (pending_q && !frame_done) || rx_finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            pending_q <= pending_d;
        end
    end

    assign fifo_rd_en = (state_q == ST_RD);
    assign tx_valid   = (state_q == ST_SEND);
    assign busy       = (state_q != ST_IDLE);
    assign tx_data    = tx_valid ? tx_byte : 8'h00;

endmodule

// File: tb/tb_fifo_word_byte_unpacker.sv
// Bench for fifo_word_byte_unpacker: two instances (MSB-first/latency 1, LSB-first/latency 2)
// fed by behavioural FIFOs, with an expected-byte scoreboard per instance.
module tb_fifo_word_byte_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_ready;
    logic        rx_finish;
    logic        fe    [2];
    logic        rd    [2];
    logic [31:0] dout  [2];
    logic [7:0]  txd   [2];
    logic        txv   [2];
    logic        busy  [2];
    logic        fd    [2];

    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    logic [7:0]  ex0[$];
    logic [7:0]  ex1[$];
    logic [31:0] pipe1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bytes   [2] = '{0, 0};
    int rd_cnt  [2] = '{0, 0};
    int fd_cnt  [2] = '{0, 0};
    int bubble  [2] = '{0, 0};
    int rd_cyc  [2] = '{0, 0};
    int last_hs [2] = '{0, 0};
    logic       pv   [2] = '{1'b0, 1'b0};
    logic       pacc [2] = '{1'b0, 1'b0};
    logic [7:0] pd   [2] = '{8'h00, 8'h00};
    logic       bubble_en = 1'b0;

    always #5 clk = ~clk;

    fifo_word_byte_unpacker #(.MSB_FIRST(1), .FIFO_RD_LAT(1)) u_dut_m (
        .clk(clk), .rst(rst), .fifo_empty(fe[0]), .fifo_rd_en(rd[0]), .fifo_dout(dout[0]),
        .rx_finish(rx_finish), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
        .busy(busy[0]), .frame_done(fd[0])
    );

    fifo_word_byte_unpacker #(.MSB_FIRST(0), .FIFO_RD_LAT(2)) u_dut_l (
        .clk(clk), .rst(rst), .fifo_empty(fe[1]), .fifo_rd_en(rd[1]), .fifo_dout(dout[1]),
        .rx_finish(rx_finish), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
        .busy(busy[1]), .frame_done(fd[1])
    );

    // Behavioural word FIFOs: instance 0 has one cycle read latency, instance 1 two.
    always @(posedge clk) begin
        if (rst) begin
            fq0.delete();
            fq1.delete();
            fe[0] <= 1'b1;
            fe[1] <= 1'b1;
            dout[0] <= 32'h0;
            dout[1] <= 32'h0;
            pipe1   <= 32'h0;
        end else begin
            if (rd[0] && fq0.size() != 0) dout[0] <= fq0.pop_front();
            if (rd[1] && fq1.size() != 0) pipe1 <= fq1.pop_front();
            dout[1] <= pipe1;
            fe[0] <= (fq0.size() == 0);
            fe[1] <= (fq1.size() == 0);
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return "0" + 8'(n);
        return "A" + 8'(n) - 8'd10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input int i, input logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = (i == 0) ? w[31 - 8*k -: 8] : w[8*k +: 8];
`ifdef UNPACK_HEX_ASCII_EN
            if (i == 0) begin ex0.push_back(hexc(b[7:4])); ex0.push_back(hexc(b[3:0])); end
            else        begin ex1.push_back(hexc(b[7:4])); ex1.push_back(hexc(b[3:0])); end
`else
            if (i == 0) ex0.push_back(b);
            else        ex1.push_back(b);
`endif
        end
`ifdef UNPACK_HEX_ASCII_EN
        if (i == 0) begin ex0.push_back(8'h0D); ex0.push_back(8'h0A); end
        else        begin ex1.push_back(8'h0D); ex1.push_back(8'h0A); end
`endif
        if (i == 0) fq0.push_back(w);
        else        fq1.push_back(w);
    endtask

    task automatic push_both(input logic [31:0] w);
        push_word(0, w);
        push_word(1, w);
    endtask

    function automatic int exp_size(input int i);
        return (i == 0) ? ex0.size() : ex1.size();
    endfunction

    task automatic pop_exp(input int i, output logic [7:0] b);
        if (i == 0) b = ex0.pop_front();
        else        b = ex1.pop_front();
    endtask

    // One clock: observe at the falling edge, then return just after the next rising edge.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pv[i] && !pacc[i]) begin
                chk("hold_valid", 32'(txv[i]), 32'd1);
                chk("hold_data", 32'(txd[i]), 32'(pd[i]));
            end
            if (txv[i] && !pv[i] && !rst)
                chk("first_valid_latency", 32'(cyc - rd_cyc[i]), 32'((i == 0) ? 2 : 3));
            if (txv[i] && tx_ready && !rst) begin
                chk("byte_expected", 32'(exp_size(i) != 0), 32'd1);
                if (exp_size(i) != 0) begin
                    pop_exp(i, e);
                    chk("byte_value", 32'(txd[i]), 32'(e));
                end
                bytes[i]++;
                last_hs[i] = cyc;
            end
            if (rd[i]) begin
                chk("rd_while_empty", 32'(fe[i]), 32'd0);
                rd_cnt[i]++;
                rd_cyc[i] = cyc;
            end
            if (fd[i]) begin
                fd_cnt[i]++;
                chk("frame_done_timing", 32'(cyc - last_hs[i]), 32'd1);
            end
            if (bubble_en && !busy[i] && exp_size(i) != 0 && rd_cnt[i] > 0) bubble[i]++;
            pv[i]   = txv[i] && !rst;
            pd[i]   = txd[i];
            pacc[i] = txv[i] && tx_ready;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int limit);
        int n = 0;
        while (n < limit && !(ex0.size() == 0 && ex1.size() == 0 && fq0.size() == 0 &&
                              fq1.size() == 0 && !busy[0] && !busy[1])) begin
            step();
            n++;
        end
        chk("drain_within_budget", 32'(n < limit), 32'd1);
    endtask

    task automatic wait_bytes0(input int target, input int limit);
        int n = 0;
        while (n < limit && bytes[0] < target) begin
            step();
            n++;
        end
        chk("byte_wait_budget", 32'(bytes[0] >= target), 32'd1);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        tx_ready  = 1'b0;
        rx_finish = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx_valid", 32'(txv[i]), 32'd0);
            chk("rst_tx_data", 32'(txd[i]), 32'h00);
            chk("rst_rd_en", 32'(rd[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_frame_done", 32'(fd[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) step();

        // Single word, sustained ready: DE AD BE EF (MSB first) and EF BE AD DE (LSB first).
        tx_ready = 1'b1;
        push_both(32'hDEADBEEF);
        run_until_done(100);
        chk("single_rd_count_m", 32'(rd_cnt[0]), 32'd1);
        chk("single_rd_count_l", 32'(rd_cnt[1]), 32'd1);
        chk("single_no_frame_done", 32'(fd_cnt[0] + fd_cnt[1]), 32'd0);

        // Back-pressure for 5 cycles while the second byte is presented.
        base = bytes[0];
        push_both(32'h12345678);
        wait_bytes0(base + 1, 50);
        tx_ready = 1'b0;
        repeat (5) step();
        chk("stall_valid_held", 32'(txv[0]), 32'd1);
        tx_ready = 1'b1;
        run_until_done(100);

        // Three queued words back-to-back with an end-of-frame marker mid-stream.
        rd_cnt    = '{0, 0};
        fd_cnt    = '{0, 0};
        bubble    = '{0, 0};
        bubble_en = 1'b1;
        push_both(32'h01234567);
        push_both(32'h89ABCDEF);
        push_both(32'hA5C3F00F);
        begin
            int n = 0;
            while (n < 20 && rd_cnt[0] < 1) begin step(); n++; end
            chk("first_read_budget", 32'(rd_cnt[0]), 32'd1);
        end
        rx_finish = 1'b1;
        step();
        rx_finish = 1'b0;
        run_until_done(200);
        repeat (3) step();
        bubble_en = 1'b0;
        chk("burst_rd_count_m", 32'(rd_cnt[0]), 32'd3);
        chk("burst_rd_count_l", 32'(rd_cnt[1]), 32'd3);
        chk("burst_idle_bubble_m", 32'(bubble[0]), 32'd0);
        chk("burst_idle_bubble_l", 32'(bubble[1]), 32'd0);
        chk("frame_done_count_m", 32'(fd_cnt[0]), 32'd1);
        chk("frame_done_count_l", 32'(fd_cnt[1]), 32'd1);

        // Reset after the first byte of a word aborts the rest of that word.
        base = bytes[0];
        push_both(32'hCAFEF00D);
        wait_bytes0(base + 1, 50);
        tx_ready = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("abort_tx_valid", 32'(txv[i]), 32'd0);
            chk("abort_busy", 32'(busy[i]), 32'd0);
        end
        ex0.delete();
        ex1.delete();
        tx_ready = 1'b1;
        repeat (6) step();
        chk("abort_no_read", 32'(rd[0] | rd[1]), 32'd0);
        push_both(32'h01020304);
        run_until_done(100);
        chk("recover_idle_m", 32'(busy[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
